// File: rtl/cp0_tlb_regfile.sv
// rtl/cp0_tlb_regfile.sv - CP0 register file with TLB-side registers, timer and interrupt request
module cp0_tlb_regfile #(
    parameter int TLBNUM    = 16,
    parameter int IDXW      = $clog2(TLBNUM),
    parameter int COUNT_DIV = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_ex,
    input  logic            wb_bd,
    input  logic            wb_eret,
    input  logic [4:0]      wb_excode,
    input  logic [31:0]     wb_pc,
    input  logic [31:0]     wb_badvaddr,
    input  logic [5:0]      ext_int_in,
    input  logic [7:0]      cp0_addr,
    input  logic            mtc0_we,
    input  logic [31:0]     cp0_wdata,
    output logic [31:0]     cp0_rdata,
    input  logic            tlbp,
    input  logic            tlbr,
    input  logic            tlbwi,
    input  logic            tlbwr,
    input  logic            s_found,
    input  logic [IDXW-1:0] s_index,
    input  logic [31:0]     r_entryhi,
    input  logic [31:0]     r_entrylo0,
    input  logic [31:0]     r_entrylo1,
    output logic            tlb_we,
    output logic [IDXW-1:0] tlb_w_index,
    output logic [31:0]     cp0_status,
    output logic [31:0]     cp0_epc,
    output logic [31:0]     cp0_entryhi,
    output logic [31:0]     cp0_entrylo0,
    output logic [31:0]     cp0_entrylo1,
    output logic            int_req
);
    localparam int              PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(COUNT_DIV - 1);
    localparam logic [IDXW-1:0] IDX_MAX   = IDXW'(TLBNUM - 1);

    localparam logic [7:0] A_INDEX    = 8'h00;
    localparam logic [7:0] A_RANDOM   = 8'h08;
    localparam logic [7:0] A_ENTRYLO0 = 8'h10;
    localparam logic [7:0] A_ENTRYLO1 = 8'h18;
    localparam logic [7:0] A_WIRED    = 8'h30;
    localparam logic [7:0] A_BADVADDR = 8'h40;
    localparam logic [7:0] A_COUNT    = 8'h48;
    localparam logic [7:0] A_ENTRYHI  = 8'h50;
    localparam logic [7:0] A_COMPARE  = 8'h58;
    localparam logic [7:0] A_STATUS   = 8'h60;
    localparam logic [7:0] A_CAUSE    = 8'h68;
    localparam logic [7:0] A_EPC      = 8'h70;

    logic [7:0]      im_q, im_d, ip_q, ip_d, asid_q, asid_d;
    logic            exl_q, exl_d, ie_q, ie_d, bd_q, bd_d, ti_q, ti_d;
    logic [4:0]      excode_q, excode_d;
    logic [31:0]     epc_q, epc_d, badvaddr_q, badvaddr_d;
    logic [31:0]     count_q, count_d, compare_q, compare_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [18:0]     vpn2_q, vpn2_d;
    logic [25:0]     entrylo0_q, entrylo0_d, entrylo1_q, entrylo1_d;
    logic            index_p_q, index_p_d, int_req_q, int_req_d;
    logic [IDXW-1:0] index_q, index_d, wired_q, wired_d, random_q, random_d;

    // A committed exception in WB squashes any mtc0 in the same instruction.
    logic mtc0_ok, tlb_exc, addr_exc, tlbr_g;
    assign mtc0_ok  = mtc0_we & ~wb_ex;
    assign tlb_exc  = wb_ex & (wb_excode >= 5'd1) & (wb_excode <= 5'd3);
    assign addr_exc = wb_ex & (wb_excode >= 5'd1) & (wb_excode <= 5'd5);
    assign tlbr_g   = r_entrylo0[0] & r_entrylo1[0];

    // TLB read data fields that have no home in the CP0 layout.
    logic unused_tlb_bits;
    assign unused_tlb_bits = ^{r_entryhi[12:8], r_entrylo0[31:26], r_entrylo1[31:26]};

    // Next-state for every CP0 register, priorities resolved by statement order.
    always_comb begin
        im_d = im_q; ie_d = ie_q; exl_d = exl_q;
        bd_d = bd_q; excode_d = excode_q; ti_d = ti_q;
        epc_d = epc_q; badvaddr_d = badvaddr_q;
        count_d = count_q; presc_d = presc_q; compare_d = compare_q;
        vpn2_d = vpn2_q; asid_d = asid_q;
        entrylo0_d = entrylo0_q; entrylo1_d = entrylo1_q;
        index_p_d = index_p_q; index_d = index_q; wired_d = wired_q;

        if (mtc0_ok && cp0_addr == A_STATUS) begin
            im_d  = cp0_wdata[15:8];
            exl_d = cp0_wdata[1];
            ie_d  = cp0_wdata[0];
        end
        if (wb_eret) exl_d = 1'b0;
        if (wb_ex)   exl_d = 1'b1;

        ip_d = {ext_int_in[5] | ti_q, ext_int_in[4:0], ip_q[1:0]};
        if (mtc0_ok && cp0_addr == A_CAUSE) ip_d[1:0] = cp0_wdata[9:8];
        if (wb_ex) begin
            excode_d = wb_excode;
            if (!exl_q) bd_d = wb_bd;
        end

        if (wb_ex) begin
            if (!exl_q) epc_d = wb_bd ? wb_pc - 32'd4 : wb_pc;
        end else if (mtc0_ok && cp0_addr == A_EPC) begin
            epc_d = cp0_wdata;
        end
        if (addr_exc) badvaddr_d = wb_badvaddr;

        if (mtc0_ok && cp0_addr == A_COUNT) begin
            count_d = cp0_wdata;
            presc_d = '0;
        end else if (presc_q == PRESC_MAX) begin
            count_d = count_q + 32'd1;
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
        if (mtc0_ok && cp0_addr == A_COMPARE) compare_d = cp0_wdata;
        if (count_q == compare_q) ti_d = 1'b1;
        if (mtc0_ok && cp0_addr == A_COMPARE) ti_d = 1'b0;

        if (mtc0_ok && cp0_addr == A_ENTRYHI) begin
            vpn2_d = cp0_wdata[31:13];
            asid_d = cp0_wdata[7:0];
        end else if (tlbr) begin
            vpn2_d = r_entryhi[31:13];
            asid_d = r_entryhi[7:0];
        end else if (tlb_exc) begin
            vpn2_d = wb_badvaddr[31:13];
        end
        if (mtc0_ok && cp0_addr == A_ENTRYLO0)  entrylo0_d = cp0_wdata[25:0];
        else if (tlbr)                          entrylo0_d = {r_entrylo0[25:1], tlbr_g};
        if (mtc0_ok && cp0_addr == A_ENTRYLO1)  entrylo1_d = cp0_wdata[25:0];
        else if (tlbr)                          entrylo1_d = {r_entrylo1[25:1], tlbr_g};

        if (tlbp) begin
            index_p_d = ~s_found;
            if (s_found) index_d = s_index;
        end else if (mtc0_ok && cp0_addr == A_INDEX) begin
            index_d = cp0_wdata[IDXW-1:0];
        end

        random_d = (random_q <= wired_q) ? IDX_MAX : random_q - 1'b1;
        if (mtc0_ok && cp0_addr == A_WIRED) begin
            wired_d  = cp0_wdata[IDXW-1:0];
            random_d = IDX_MAX;
        end

        int_req_d = ~wb_ex & ie_q & ~exl_q & (|(ip_q & im_q));
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            im_q <= '0; ie_q <= 1'b0; exl_q <= 1'b0;
            bd_q <= 1'b0; ti_q <= 1'b0; ip_q <= '0; excode_q <= '0;
            epc_q <= '0; badvaddr_q <= '0;
            count_q <= '0; presc_q <= '0; compare_q <= '0;
            vpn2_q <= '0; asid_q <= '0; entrylo0_q <= '0; entrylo1_q <= '0;
            index_p_q <= 1'b0; index_q <= '0; wired_q <= '0; random_q <= IDX_MAX;
            int_req_q <= 1'b0;
        end else begin
            im_q <= im_d; ie_q <= ie_d; exl_q <= exl_d;
            bd_q <= bd_d; ti_q <= ti_d; ip_q <= ip_d; excode_q <= excode_d;
            epc_q <= epc_d; badvaddr_q <= badvaddr_d;
            count_q <= count_d; presc_q <= presc_d; compare_q <= compare_d;
            vpn2_q <= vpn2_d; asid_q <= asid_d; entrylo0_q <= entrylo0_d; entrylo1_q <= entrylo1_d;
            index_p_q <= index_p_d; index_q <= index_d; wired_q <= wired_d; random_q <= random_d;
            int_req_q <= int_req_d;
        end
    end

    assign cp0_status   = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cp0_epc      = epc_q;
    assign cp0_entryhi  = {vpn2_q, 5'b0, asid_q};
    assign cp0_entrylo0 = {6'b0, entrylo0_q};
    assign cp0_entrylo1 = {6'b0, entrylo1_q};
    assign int_req      = int_req_q;
    assign tlb_we       = tlbwi | tlbwr;
    assign tlb_w_index  = tlbwr ? random_q : index_q;

    // mfc0 read mux; unmapped addresses return zero.
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            A_INDEX:    cp0_rdata = {index_p_q, {(31-IDXW){1'b0}}, index_q};
            A_RANDOM:   cp0_rdata = {{(32-IDXW){1'b0}}, random_q};
            A_ENTRYLO0: cp0_rdata = cp0_entrylo0;
            A_ENTRYLO1: cp0_rdata = cp0_entrylo1;
            A_WIRED:    cp0_rdata = {{(32-IDXW){1'b0}}, wired_q};
            A_BADVADDR: cp0_rdata = badvaddr_q;
            A_COUNT:    cp0_rdata = count_q;
            A_ENTRYHI:  cp0_rdata = cp0_entryhi;
            A_COMPARE:  cp0_rdata = compare_q;
            A_STATUS:   cp0_rdata = cp0_status;
            A_CAUSE:    cp0_rdata = {bd_q, ti_q, 14'b0, ip_q, 1'b0, excode_q, 2'b0};
            A_EPC:      cp0_rdata = epc_q;
            default:    cp0_rdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_cp0_tlb_regfile.sv
// tb/tb_cp0_tlb_regfile.sv - self-checking bench for cp0_tlb_regfile
module tb_cp0_tlb_regfile;
    localparam int TLBNUM = 16;
    localparam int IDXW   = 4;
    localparam int CDIV   = 2;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst, wb_ex, wb_bd, wb_eret, mtc0_we, tlbp, tlbr, tlbwi, tlbwr, s_found;
    logic [4:0] wb_excode;
    logic [31:0] wb_pc, wb_badvaddr, cp0_wdata, cp0_rdata, r_entryhi, r_entrylo0, r_entrylo1;
    logic [5:0] ext_int_in;
    logic [7:0] cp0_addr;
    logic [IDXW-1:0] s_index, tlb_w_index;
    logic tlb_we, int_req;
    logic [31:0] cp0_status, cp0_epc, cp0_entryhi, cp0_entrylo0, cp0_entrylo1;

    cp0_tlb_regfile #(.TLBNUM(TLBNUM), .IDXW(IDXW), .COUNT_DIV(CDIV)) dut (
        .clk(clk), .rst(rst), .wb_ex(wb_ex), .wb_bd(wb_bd), .wb_eret(wb_eret),
        .wb_excode(wb_excode), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr),
        .ext_int_in(ext_int_in), .cp0_addr(cp0_addr), .mtc0_we(mtc0_we),
        .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .tlbp(tlbp), .tlbr(tlbr),
        .tlbwi(tlbwi), .tlbwr(tlbwr), .s_found(s_found), .s_index(s_index),
        .r_entryhi(r_entryhi), .r_entrylo0(r_entrylo0), .r_entrylo1(r_entrylo1),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .cp0_status(cp0_status),
        .cp0_epc(cp0_epc), .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0),
        .cp0_entrylo1(cp0_entrylo1), .int_req(int_req)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  im, ip, asid;
        logic        exl, ie, bd, ti, ip_p, intreq;
        logic [4:0]  excode;
        logic [31:0] epc, bad, count, compare, lo0, lo1;
        logic [18:0] vpn2;
        int          presc, idx, wired, rnd;
    } mstate_t;
    mstate_t m;

    typedef struct { logic [7:0] addr; logic [31:0] exp; } rvec_t;
    typedef struct { logic [7:0] addr; logic [31:0] wdata; logic [31:0] exp; } wvec_t;
    rvec_t rtab[13];
    wvec_t wtab[12];
    logic [7:0] addrs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m = '{im: 8'h0, ip: 8'h0, asid: 8'h0, exl: 1'b0, ie: 1'b0, bd: 1'b0, ti: 1'b0,
              ip_p: 1'b0, intreq: 1'b0, excode: 5'h0, epc: 32'h0, bad: 32'h0, count: 32'h0,
              compare: 32'h0, lo0: 32'h0, lo1: 32'h0, vpn2: 19'h0, presc: 0, idx: 0,
              wired: 0, rnd: TLBNUM - 1};
    endtask

    // Advance the reference by one clock using the inputs currently applied.
    task automatic model_step();
        mstate_t n;
        logic we;
        logic g;
        if (rst) begin
            model_reset();
            return;
        end
        n  = m;
        we = mtc0_we && !wb_ex;
        n.intreq = !wb_ex && m.ie && !m.exl && ((m.ip & m.im) != 8'h0);
        if (we && cp0_addr == 8'h60) begin
            n.im = cp0_wdata[15:8]; n.ie = cp0_wdata[0]; n.exl = cp0_wdata[1];
        end
        if (wb_ex) n.exl = 1'b1;
        else if (wb_eret) n.exl = 1'b0;
        n.ip = {ext_int_in[5] | m.ti, ext_int_in[4:0], (we && cp0_addr == 8'h68) ? cp0_wdata[9:8] : m.ip[1:0]};
        if (wb_ex) begin
            n.excode = wb_excode;
            if (!m.exl) begin
                n.bd  = wb_bd;
                n.epc = wb_bd ? wb_pc - 32'd4 : wb_pc;
            end
            if (wb_excode >= 1 && wb_excode <= 5) n.bad = wb_badvaddr;
        end else if (we && cp0_addr == 8'h70) n.epc = cp0_wdata;
        if (we && cp0_addr == 8'h48) begin
            n.count = cp0_wdata; n.presc = 0;
        end else begin
            n.presc = (m.presc + 1) % CDIV;
            if (n.presc == 0) n.count = m.count + 1;
        end
        if (we && cp0_addr == 8'h58) begin
            n.compare = cp0_wdata; n.ti = 1'b0;
        end else if (m.count == m.compare) n.ti = 1'b1;
        g = r_entrylo0[0] & r_entrylo1[0];
        if (we && cp0_addr == 8'h50) begin
            n.vpn2 = cp0_wdata[31:13]; n.asid = cp0_wdata[7:0];
        end else if (tlbr) begin
            n.vpn2 = r_entryhi[31:13]; n.asid = r_entryhi[7:0];
        end else if (wb_ex && wb_excode >= 1 && wb_excode <= 3) n.vpn2 = wb_badvaddr[31:13];
        if (we && cp0_addr == 8'h10) n.lo0 = cp0_wdata & 32'h03FF_FFFF;
        else if (tlbr) n.lo0 = (r_entrylo0 & 32'h03FF_FFFE) | 32'(g);
        if (we && cp0_addr == 8'h18) n.lo1 = cp0_wdata & 32'h03FF_FFFF;
        else if (tlbr) n.lo1 = (r_entrylo1 & 32'h03FF_FFFE) | 32'(g);
        if (tlbp) begin
            n.ip_p = !s_found;
            if (s_found) n.idx = int'(s_index);
        end else if (we && cp0_addr == 8'h00) n.idx = int'(cp0_wdata % 32'(TLBNUM));
        if (we && cp0_addr == 8'h30) begin
            n.wired = int'(cp0_wdata % 32'(TLBNUM)); n.rnd = TLBNUM - 1;
        end else n.rnd = (m.rnd <= m.wired) ? TLBNUM - 1 : m.rnd - 1;
        m = n;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a)
            8'h00: return (m.ip_p ? 32'h8000_0000 : 32'h0) + 32'(m.idx);
            8'h08: return 32'(m.rnd);
            8'h10: return m.lo0;
            8'h18: return m.lo1;
            8'h30: return 32'(m.wired);
            8'h40: return m.bad;
            8'h48: return m.count;
            8'h50: return (32'(m.vpn2) << 13) + 32'(m.asid);
            8'h58: return m.compare;
            8'h60: return 32'h0040_0000 + (32'(m.im) << 8) + (32'(m.exl) << 1) + 32'(m.ie);
            8'h68: return (32'(m.bd) << 31) + (32'(m.ti) << 30) + (32'(m.ip) << 8) + (32'(m.excode) << 2);
            8'h70: return m.epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; wb_ex = 1'b0; wb_bd = 1'b0; wb_eret = 1'b0; wb_excode = 5'd0;
        wb_pc = 32'h0; wb_badvaddr = 32'h0; ext_int_in = 6'h0; cp0_addr = 8'h0;
        mtc0_we = 1'b0; cp0_wdata = 32'h0; tlbp = 1'b0; tlbr = 1'b0; tlbwi = 1'b0;
        tlbwr = 1'b0; s_found = 1'b0; s_index = '0; r_entryhi = 32'h0;
        r_entrylo0 = 32'h0; r_entrylo1 = 32'h0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        mtc0_we = 1'b1; cp0_addr = a; cp0_wdata = d;
        tick();
        mtc0_we = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [7:0] a, input logic [31:0] exp);
        cp0_addr = a;
        #1;
        chk(name, cp0_rdata, exp);
    endtask

    task automatic wb_clear();
        wb_ex = 1'b0; wb_bd = 1'b0; wb_eret = 1'b0; wb_excode = 5'd0;
        wb_pc = 32'h0; wb_badvaddr = 32'h0;
    endtask

    initial begin
        int r;
        rtab = '{'{8'h00, 32'h0}, '{8'h08, 32'hF}, '{8'h10, 32'h0}, '{8'h18, 32'h0},
                 '{8'h30, 32'h0}, '{8'h40, 32'h0}, '{8'h48, 32'h0}, '{8'h50, 32'h0},
                 '{8'h58, 32'h0}, '{8'h60, 32'h0040_0000}, '{8'h68, 32'h0},
                 '{8'h70, 32'h0}, '{8'h01, 32'h0}};
        wtab = '{'{8'h58, 32'hFFFF_FF00, 32'hFFFF_FF00}, '{8'h48, 32'h100, 32'h100},
                 '{8'h60, 32'hFFFF_FFFF, 32'h0040_FF03}, '{8'h50, 32'hFFFF_FFFF, 32'hFFFF_E0FF},
                 '{8'h10, 32'hFFFF_FFFF, 32'h03FF_FFFF}, '{8'h18, 32'h5555_5555, 32'h0155_5555},
                 '{8'h00, 32'hFFFF_FFFF, 32'h0000_000F}, '{8'h40, 32'h1234_5678, 32'h0},
                 '{8'h70, 32'hDEAD_BEEF, 32'hDEAD_BEEF}, '{8'h68, 32'hFFFF_FFFF, 32'h0000_0300},
                 '{8'h01, 32'hFFFF_FFFF, 32'h0}, '{8'h30, 32'h2, 32'h2}};
        addrs = '{8'h00, 8'h08, 8'h10, 8'h18, 8'h30, 8'h40, 8'h48, 8'h50,
                  8'h58, 8'h60, 8'h68, 8'h70, 8'h01, 8'h20, 8'hF8};

        idle();
        rst = 1'b1;
        tick(); tick();
        chk("rst_int_req", 32'(int_req), 32'h0);
        chk("rst_tlb_we", 32'(tlb_we), 32'h0);
        for (int i = 0; i < 13; i++) chk_rd($sformatf("rst_rd_%02h", rtab[i].addr), rtab[i].addr, rtab[i].exp);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            wr(wtab[i].addr, wtab[i].wdata);
            chk_rd($sformatf("wr_%02h", wtab[i].addr), wtab[i].addr, wtab[i].exp);
        end

        // First exception with EXL clear, in a delay slot, TLBL
        wr(8'h60, 32'h0); wr(8'h68, 32'h0);
        wb_ex = 1'b1; wb_bd = 1'b1; wb_pc = 32'hBFC0_0104; wb_excode = 5'd2; wb_badvaddr = 32'h0040_2ABC;
        tick(); wb_clear();
        chk("exc_epc", cp0_epc, 32'hBFC0_0100);
        chk_rd("exc_cause", 8'h68, 32'h8000_0008);
        chk("exc_status", cp0_status, 32'h0040_0002);
        chk_rd("exc_badvaddr", 8'h40, 32'h0040_2ABC);
        chk("exc_entryhi", cp0_entryhi, 32'h0040_20FF);

        // Nested exception keeps EPC and BD, then eret drops EXL
        wb_ex = 1'b1; wb_pc = 32'h80; wb_excode = 5'd0;
        tick(); wb_clear();
        chk("nest_epc", cp0_epc, 32'hBFC0_0100);
        chk_rd("nest_cause", 8'h68, 32'h8000_0000);
        wb_eret = 1'b1; tick(); wb_clear();
        chk("eret_status", cp0_status, 32'h0040_0000);

        // mtc0 EPC squashed by a same-cycle exception
        wb_ex = 1'b1; wb_pc = 32'h1000; mtc0_we = 1'b1; cp0_addr = 8'h70; cp0_wdata = 32'hAAAA_5555;
        tick(); wb_clear(); mtc0_we = 1'b0;
        chk("prio_epc", cp0_epc, 32'h1000);
        wb_eret = 1'b1; tick(); wb_clear();

        // Wired/Random walk with a tlbwr at Random=9
        wr(8'h30, 32'h4);
        r = 15;
        for (int k = 0; k < 13; k++) begin
            chk_rd($sformatf("random_%0d", k), 8'h08, 32'(r));
            if (r == 9) begin
                tlbwr = 1'b1; #1;
                chk("tlbwr_we", 32'(tlb_we), 32'h1);
                chk("tlbwr_idx", 32'(tlb_w_index), 32'h9);
            end
            tick(); tlbwr = 1'b0;
            r = (r <= 4) ? 15 : r - 1;
        end

        // Timer interrupt path
        wr(8'h60, 32'h0000_8001); wr(8'h58, 32'h5); wr(8'h48, 32'h0);
        repeat (10) tick();
        chk_rd("timer_count", 8'h48, 32'h5);
        chk_rd("timer_cause0", 8'h68, 32'h0);
        tick(); chk_rd("timer_ti", 8'h68, 32'h4000_0000);
        tick(); chk_rd("timer_ip7", 8'h68, 32'h4000_8000); chk("timer_irq_pre", 32'(int_req), 32'h0);
        tick(); chk("timer_irq", 32'(int_req), 32'h1);
        wr(8'h58, 32'h100); chk_rd("timer_ti_clr", 8'h68, 32'h0000_8000);
        wr(8'h60, 32'h0);

        // tlbp miss/hit, tlbwi, tlbr with G merge
        tlbp = 1'b1; s_found = 1'b0; s_index = 4'd3; tick(); tlbp = 1'b0;
        chk_rd("tlbp_miss", 8'h00, 32'h8000_000F);
        tlbp = 1'b1; s_found = 1'b1; s_index = 4'd7; tick(); tlbp = 1'b0; s_found = 1'b0;
        chk_rd("tlbp_hit", 8'h00, 32'h7);
        tlbwi = 1'b1; #1;
        chk("tlbwi_we", 32'(tlb_we), 32'h1);
        chk("tlbwi_idx", 32'(tlb_w_index), 32'h7);
        tick(); tlbwi = 1'b0;
        tlbr = 1'b1; r_entryhi = 32'h1234_5FFF; r_entrylo0 = 32'h41; r_entrylo1 = 32'h86;
        tick(); tlbr = 1'b0;
        chk("tlbr_lo0", cp0_entrylo0, 32'h40);
        chk("tlbr_lo1", cp0_entrylo1, 32'h86);
        chk("tlbr_hi", cp0_entryhi, 32'h1234_40FF);
        chk("tlb_we_idle", 32'(tlb_we), 32'h0);

        // Reset mid-count
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk_rd("rst_mid_count", 8'h48, 32'h0);
        chk_rd("rst_mid_random", 8'h08, 32'hF);
        chk("rst_mid_status", cp0_status, 32'h0040_0000);

        // Randomized traffic against the reference model
        for (int i = 0; i < 2000; i++) begin
            int op;
            rst = ($urandom_range(0, 199) == 0);
            wb_ex = ($urandom_range(0, 15) == 0);
            wb_eret = ($urandom_range(0, 15) == 0);
            wb_bd = 1'($urandom);
            wb_excode = 5'($urandom_range(0, 7));
            wb_pc = $urandom; wb_badvaddr = $urandom;
            ext_int_in = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
            mtc0_we = ($urandom_range(0, 2) == 0);
            cp0_addr = addrs[$urandom_range(0, 14)];
            cp0_wdata = $urandom;
            if ((cp0_addr == 8'h58 || cp0_addr == 8'h48) && $urandom_range(0, 1) == 1)
                cp0_wdata = m.count + 32'($urandom_range(0, 8));
            op = $urandom_range(0, 9);
            tlbp = (op == 0); tlbr = (op == 1); tlbwi = (op == 2); tlbwr = (op == 3);
            s_found = 1'($urandom); s_index = IDXW'($urandom);
            r_entryhi = $urandom; r_entrylo0 = $urandom; r_entrylo1 = $urandom;
            #1;
            chk("rnd_rdata", cp0_rdata, model_read(cp0_addr));
            chk("rnd_tlb_we", 32'(tlb_we), 32'(tlbwi | tlbwr));
            chk("rnd_tlb_idx", 32'(tlb_w_index), 32'(tlbwr ? m.rnd : m.idx));
            tick();
            chk("rnd_status", cp0_status, model_read(8'h60));
            chk("rnd_epc", cp0_epc, m.epc);
            chk("rnd_entryhi", cp0_entryhi, model_read(8'h50));
            chk("rnd_lo0", cp0_entrylo0, m.lo0);
            chk("rnd_lo1", cp0_entrylo1, m.lo1);
            chk("rnd_int_req", 32'(int_req), 32'(m.intreq));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
